// File: rtl/rs_issue_sched.sv
// Issue scheduler: round-robin pick of one ready RS entry per FU class, offer hold until
// accept, and CDB writeback-slot reservation so ALU/MULT/LOAD results never collide.
module rs_issue_sched #(
    parameter int N_ENT    = 5,
    parameter int IDX_W    = 3,
    parameter int MULT_LAT = 4,
    parameter int LD_LAT   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [N_ENT-1:0]     req_valid,
    input  logic [2*N_ENT-1:0]   req_fu,
    output logic [3:0]           issue_valid,
    output logic [4*IDX_W-1:0]   issue_idx,
    input  logic [3:0]           issue_ready,
    output logic [N_ENT-1:0]     issued_mask
);

    localparam int ALU   = 0;
    localparam int MULT  = 1;
    localparam int LOAD  = 2;
    localparam int STORE = 3;

    // Pointer arithmetic wraps at N_ENT, not at 2^IDX_W.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= N_ENT) s = s - N_ENT;
        return IDX_W'(s);
    endfunction

    logic [3:0]          hold_v;
    logic [IDX_W-1:0]    hold_idx [4];
    logic [IDX_W-1:0]    ptr      [4];
    logic [MULT_LAT-1:0] r;
    logic [MULT_LAT-1:0] r_next;

    logic [N_ENT-1:0]    match    [4];
    logic [3:0]          cand_v;
    logic [IDX_W-1:0]    cand_idx [4];
    logic [IDX_W-1:0]    pos;
    logic [3:0]          slot_ok;
    logic [3:0]          accept;
    logic                block;

    assign block = reset | flush;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N_ENT; i++) begin
                match[c][i] = req_valid[i] && (req_fu[2*i +: 2] == 2'(c));
            end
        end
    end

    // Scan from the far end back toward ptr so the closest match wins.
    always_comb begin
        pos = '0;
        for (int c = 0; c < 4; c++) begin
            cand_v[c]   = hold_v[c];
            cand_idx[c] = hold_idx[c];
            if (!hold_v[c]) begin
                for (int k = N_ENT - 1; k >= 0; k--) begin
                    pos = wrap_add(ptr[c], k);
                    if (match[c][pos]) begin
                        cand_v[c]   = 1'b1;
                        cand_idx[c] = pos;
                    end
                end
            end
        end
    end

    // R[k] set means CDB cycle t+k+1 is already claimed.
    always_comb begin
        slot_ok[ALU]   = !r[0];
        slot_ok[MULT]  = !r[MULT_LAT-1];
        slot_ok[LOAD]  = !r[LD_LAT-1];
        slot_ok[STORE] = 1'b1;
        issue_valid = cand_v & slot_ok & {4{!block}};
        for (int c = 0; c < 4; c++) begin
            issue_idx[c*IDX_W +: IDX_W] = (cand_v[c] && !block) ? cand_idx[c] : '0;
        end
    end

    assign accept = issue_valid & issue_ready;

    always_comb begin
        issued_mask = '0;
        for (int c = 0; c < 4; c++) begin
            if (accept[c]) issued_mask[cand_idx[c]] = 1'b1;
        end
    end

    always_comb begin
        r_next = r >> 1;
        if (accept[MULT]) r_next[MULT_LAT-2] = 1'b1;
        if (accept[LOAD]) r_next[LD_LAT-2]   = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (block) begin
            hold_v <= '0;
            r      <= '0;
            for (int c = 0; c < 4; c++) ptr[c] <= '0;
        end else begin
            r <= r_next;
            for (int c = 0; c < 4; c++) begin
                if (accept[c]) begin
                    hold_v[c] <= 1'b0;
                    ptr[c]    <= wrap_add(cand_idx[c], 1);
                end else if (issue_valid[c]) begin
                    hold_v[c] <= 1'b1;
                end
            end
        end
    end

    // Held index is only meaningful while hold_v is set, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int c = 0; c < 4; c++) begin
            if (issue_valid[c] && !issue_ready[c]) hold_idx[c] <= cand_idx[c];
        end
    end

endmodule
